// File: rtl/ram_arbiter_if.sv
// Signal bundle for ram_arbiter: two requester ports, RAM-side bus and status.
// The slave modport is the arbiter's view; master is the CPU/RAM environment.
interface ram_arbiter_if #(
   parameter int BIT = 8,
   parameter int SZB = 4
);
   logic           req0_valid, req0_ready, req0_we;
   logic [SZB-1:0] req0_addr;
   logic [BIT-1:0] req0_d;
   logic           req1_valid, req1_ready, req1_we;
   logic [SZB-1:0] req1_addr;
   logic [BIT-1:0] req1_d;
   logic           rsp0_valid, rsp1_valid;
   logic [BIT-1:0] rsp0_q, rsp1_q;
   logic           ram_we;
   logic [SZB-1:0] ram_addr;
   logic [BIT-1:0] ram_d, ram_q;
   logic           init_done;

   modport master (
      output req0_valid, req0_we, req0_addr, req0_d,
             req1_valid, req1_we, req1_addr, req1_d, ram_q,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_q, rsp1_q,
             ram_we, ram_addr, ram_d, init_done
   );

   modport slave (
      input  req0_valid, req0_we, req0_addr, req0_d,
             req1_valid, req1_we, req1_addr, req1_d, ram_q,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_q, rsp1_q,
             ram_we, ram_addr, ram_d, init_done
   );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between instruction
// fetch (port 0) and load/store (port 1), with an optional zero-fill sweep after reset.
module ram_arbiter #(
   parameter int BIT            = 8,
   parameter int SZB            = 4,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input logic         clock,
   input logic         reset,
   ram_arbiter_if.slave bus
);
   typedef enum logic [1:0] {INIT, IDLE, ACCESS, WAIT} state_t;

   localparam state_t         RST_STATE = CLEAR_ON_RESET ? INIT : IDLE;
   localparam logic [SZB-1:0] LAST_ADDR = '1;

   state_t         state_q, state_d;
   logic [SZB-1:0] cnt_q, cnt_d;
   logic           last_grant_q, last_grant_d;
   logic           port_q, port_d;
   logic           op_we_q, op_we_d;
   logic           ram_we_q, ram_we_d;
   logic [SZB-1:0] ram_addr_q, ram_addr_d;
   logic [BIT-1:0] ram_d_q, ram_d_d;
   logic           rsp0_valid_q, rsp0_valid_d;
   logic           rsp1_valid_q, rsp1_valid_d;
   logic [BIT-1:0] rsp0_q_q, rsp0_q_d;
   logic [BIT-1:0] rsp1_q_q, rsp1_q_d;
   logic           init_done_q, init_done_d;

   logic gnt0, gnt1, accept;

   // Ties go to the port that did not win last; last_grant resets to 1 so port 0 wins first.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset && state_q == IDLE) begin
         if (bus.req0_valid && bus.req1_valid) begin
            gnt0 = last_grant_q;
            gnt1 = ~last_grant_q;
         end else begin
            gnt0 = bus.req0_valid;
            gnt1 = bus.req1_valid;
         end
      end
   end

   assign accept         = gnt0 | gnt1;
   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= RST_STATE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) state_d = IDLE;
         end
         IDLE:   if (accept) state_d = ACCESS;
         ACCESS: state_d = op_we_q ? IDLE : WAIT;
         WAIT:   state_d = IDLE;
      endcase
   end

   always_comb begin
      ram_we_d     = 1'b0;
      ram_addr_d   = ram_addr_q;
      ram_d_d      = ram_d_q;
      rsp0_valid_d = 1'b0;
      rsp1_valid_d = 1'b0;
      rsp0_q_d     = rsp0_q_q;
      rsp1_q_d     = rsp1_q_q;
      init_done_d  = init_done_q | (state_d == IDLE);
      last_grant_d = last_grant_q;
      port_d       = port_q;
      op_we_d      = op_we_q;
      case (state_q)
         INIT: begin
            ram_we_d   = 1'b1;
            ram_addr_d = cnt_q;
            ram_d_d    = '0;
         end
         IDLE: begin
            if (accept) begin
               ram_we_d     = gnt1 ? bus.req1_we   : bus.req0_we;
               ram_addr_d   = gnt1 ? bus.req1_addr : bus.req0_addr;
               ram_d_d      = gnt1 ? bus.req1_d    : bus.req0_d;
               op_we_d      = ram_we_d;
               port_d       = gnt1;
               last_grant_d = gnt1;
            end
         end
         ACCESS: begin
            // Writes complete here; reads wait one more cycle for ram_q.
            if (op_we_q) begin
               rsp0_valid_d = ~port_q;
               rsp1_valid_d = port_q;
            end
         end
         WAIT: begin
            rsp0_valid_d = ~port_q;
            rsp1_valid_d = port_q;
            if (port_q) rsp1_q_d = bus.ram_q;
            else        rsp0_q_d = bus.ram_q;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_d_q      <= '0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_q_q     <= '0;
         rsp1_q_q     <= '0;
         init_done_q  <= 1'b0;
         last_grant_q <= 1'b1;
         port_q       <= 1'b0;
         op_we_q      <= 1'b0;
      end else begin
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_d_q      <= ram_d_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp0_q_q     <= rsp0_q_d;
         rsp1_q_q     <= rsp1_q_d;
         init_done_q  <= init_done_d;
         last_grant_q <= last_grant_d;
         port_q       <= port_d;
         op_we_q      <= op_we_d;
      end
   end

   assign bus.ram_we     = ram_we_q;
   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_d      = ram_d_q;
   assign bus.rsp0_valid = rsp0_valid_q;
   assign bus.rsp1_valid = rsp1_valid_q;
   assign bus.rsp0_q     = rsp0_q_q;
   assign bus.rsp1_q     = rsp1_q_q;
   assign bus.init_done  = init_done_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a transaction-level model predicts grants, RAM traffic and
// responses from the latency/arbitration rules; a second instance covers CLEAR_ON_RESET=0.
module tb_ram_arbiter;
   localparam int BIT = 8, SZB = 4, DEPTH = 16, SWEEP = 16;

   logic clock = 1'b0;
   logic rst_a = 1'b1, rst_b = 1'b1;
   always #5 clock = ~clock;

   ram_arbiter_if #(.BIT(BIT), .SZB(SZB)) ifa ();
   ram_arbiter_if #(.BIT(BIT), .SZB(SZB)) ifb ();

   ram_arbiter #(.BIT(BIT), .SZB(SZB), .CLEAR_ON_RESET(1'b1)) dut_a (
      .clock(clock), .reset(rst_a), .bus(ifa.slave));
   ram_arbiter #(.BIT(BIT), .SZB(SZB), .CLEAR_ON_RESET(1'b0)) dut_b (
      .clock(clock), .reset(rst_b), .bus(ifb.slave));

   // Synchronous single-port RAMs, read-before-write, 1-cycle read latency.
   logic [BIT-1:0] ram_a [DEPTH];
   logic [BIT-1:0] ram_b [DEPTH];
   always @(posedge clock) begin
      if (ifa.ram_we) ram_a[ifa.ram_addr] <= ifa.ram_d;
      ifa.ram_q <= ram_a[ifa.ram_addr];
      if (ifb.ram_we) ram_b[ifb.ram_addr] <= ifb.ram_d;
      ifb.ram_q <= ram_b[ifb.ram_addr];
   end

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Model state: cycle index since reset release, when the arbiter is next free, memory image.
   int             cyc, free_at, acc_cyc, pend_cyc;
   bit             m_last, pend, pend_port, pend_rd, acc_we;
   logic [3:0]     acc_addr;
   logic [7:0]     acc_d, pend_data;
   logic [7:0]     m_mem [DEPTH];
   logic [7:0]     m_q [2];
   int             dut_acc [2];
   int             dut_rsp [2];
   // Requester state: mode 0 = drop after accept, 1 = re-present same, 2 = random.
   bit             pv [2], pwe [2], took [2];
   logic [3:0]     pa [2];
   logic [7:0]     pd [2];
   int             mode [2];
   int             gnt_log [$];
   logic [7:0]     rd0_log [$];

   task automatic model_reset();
      cyc = 0; free_at = SWEEP; m_last = 1'b1; pend = 1'b0; acc_cyc = -10;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      m_q[0] = 8'h00; m_q[1] = 8'h00;
      dut_acc[0] = -1; dut_acc[1] = -1; dut_rsp[0] = -1; dut_rsp[1] = -1;
      pv[0] = 1'b0; pv[1] = 1'b0; took[0] = 1'b0; took[1] = 1'b0;
   endtask

   task automatic drive_a();
      ifa.req0_valid = pv[0]; ifa.req0_we = pwe[0]; ifa.req0_addr = pa[0]; ifa.req0_d = pd[0];
      ifa.req1_valid = pv[1]; ifa.req1_we = pwe[1]; ifa.req1_addr = pa[1]; ifa.req1_d = pd[1];
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ctl"}, 32'({ifa.ram_we, ifa.ram_addr, ifa.ram_d, ifa.rsp0_valid, ifa.rsp1_valid,
                              ifa.init_done, ifa.req0_ready, ifa.req1_ready}), 0);
      chk({tag, "_q"}, 32'({ifa.rsp0_q, ifa.rsp1_q}), 0);
   endtask

   task automatic check_outputs();
      bit ev [2];
      if (cyc >= 1 && cyc <= SWEEP) begin
         chk("sweep_we", 32'(ifa.ram_we), 1);
         chk("sweep_addr", 32'(ifa.ram_addr), cyc - 1);
         chk("sweep_d", 32'(ifa.ram_d), 0);
      end else if (cyc == acc_cyc + 1) begin
         chk("ram_we", 32'(ifa.ram_we), 32'(acc_we));
         chk("ram_addr", 32'(ifa.ram_addr), 32'(acc_addr));
         if (acc_we) chk("ram_d", 32'(ifa.ram_d), 32'(acc_d));
      end else begin
         chk("ram_we_idle", 32'(ifa.ram_we), 0);
      end
      chk("init_done", 32'(ifa.init_done), 32'(cyc >= SWEEP));
      ev[0] = 1'b0; ev[1] = 1'b0;
      if (pend && cyc == pend_cyc) begin
         ev[pend_port] = 1'b1;
         if (pend_rd) m_q[pend_port] = pend_data;
         pend = 1'b0;
      end
      chk("rsp0_valid", 32'(ifa.rsp0_valid), 32'(ev[0]));
      chk("rsp1_valid", 32'(ifa.rsp1_valid), 32'(ev[1]));
      chk("rsp0_q", 32'(ifa.rsp0_q), 32'(m_q[0]));
      chk("rsp1_q", 32'(ifa.rsp1_q), 32'(m_q[1]));
      if (ifa.rsp0_valid) begin dut_rsp[0] = cyc; rd0_log.push_back(ifa.rsp0_q); end
      if (ifa.rsp1_valid) dut_rsp[1] = cyc;
   endtask

   task automatic tick();
      bit er [2];
      bit r [2];
      int g;
      for (int p = 0; p < 2; p++) begin
         if (took[p]) begin
            if (mode[p] != 1) pv[p] = 1'b0;
            took[p] = 1'b0;
         end
         if (mode[p] == 2 && !pv[p] && $urandom_range(0, 3) != 0) begin
            pv[p]  = 1'b1;
            pwe[p] = 1'($urandom_range(0, 1));
            pa[p]  = 4'($urandom_range(0, 15));
            pd[p]  = 8'($urandom);
         end
      end
      drive_a();
      #1;
      r[0] = ifa.req0_ready; r[1] = ifa.req1_ready;
      er[0] = 1'b0; er[1] = 1'b0; g = -1;
      if (cyc >= free_at) begin
         if (pv[0] && pv[1]) g = m_last ? 0 : 1;
         else if (pv[0])     g = 0;
         else if (pv[1])     g = 1;
      end
      if (g >= 0) er[g] = 1'b1;
      chk("ready0", 32'(r[0]), 32'(er[0]));
      chk("ready1", 32'(r[1]), 32'(er[1]));
      for (int p = 0; p < 2; p++)
         if (r[p] && pv[p]) begin gnt_log.push_back(p); dut_acc[p] = cyc; end
      if (g >= 0) begin
         took[g] = 1'b1; m_last = g[0]; acc_cyc = cyc;
         acc_we = pwe[g]; acc_addr = pa[g]; acc_d = pd[g];
         pend = 1'b1; pend_port = g[0]; pend_rd = !pwe[g];
         if (pwe[g]) begin
            m_mem[pa[g]] = pd[g];
            pend_cyc = cyc + 2;
         end else begin
            pend_data = m_mem[pa[g]];
            pend_cyc = cyc + 3;
         end
         free_at = pend_cyc;
      end
      @(posedge clock);
      cyc++;
      @(negedge clock);
      check_outputs();
   endtask

   task automatic issue(input int p, input bit we, input logic [3:0] a, input logic [7:0] d);
      int n = 0;
      pv[p] = 1'b1; pwe[p] = we; pa[p] = a; pd[p] = d; mode[p] = 0; took[p] = 1'b0;
      while (!took[p] && n < 50) begin tick(); n++; end
      if (n >= 50) chk("issue_timeout", 0, 1);
      repeat (4) tick();
   endtask

   task automatic do_reset_a();
      rst_a = 1'b1;
      pv[0] = 1'b0; pv[1] = 1'b0;
      drive_a();
      @(posedge clock); #1;
      check_zero("reset");
      @(posedge clock);
      @(negedge clock);
      rst_a = 1'b0;
      model_reset();
   endtask

   initial begin
      pwe[0] = 1'b0; pwe[1] = 1'b0; pa[0] = '0; pa[1] = '0; pd[0] = '0; pd[1] = '0;
      mode[0] = 0; mode[1] = 0;
      ifb.req0_valid = 1'b0; ifb.req0_we = 1'b0; ifb.req0_addr = '0; ifb.req0_d = '0;
      ifb.req1_valid = 1'b0; ifb.req1_we = 1'b0; ifb.req1_addr = '0; ifb.req1_d = '0;
      model_reset();
      do_reset_a();

      // Port 0 read held through the sweep; first grant lands in the first IDLE cycle.
      pv[0] = 1'b1; pwe[0] = 1'b0; pa[0] = 4'd0; pd[0] = 8'h00;
      repeat (20) tick();
      chk("hold_accept_cyc", dut_acc[0], SWEEP);
      issue(0, 1'b0, 4'd7, 8'h00);
      chk("rd7", 32'(ifa.rsp0_q), 0);
      issue(0, 1'b0, 4'd15, 8'h00);
      chk("rd15", 32'(ifa.rsp0_q), 0);

      issue(1, 1'b1, 4'd3, 8'hA5);
      chk("wr_latency", dut_rsp[1] - dut_acc[1], 2);
      issue(1, 1'b0, 4'd3, 8'h00);
      chk("rd_latency", dut_rsp[1] - dut_acc[1], 3);
      chk("rd_a5", 32'(ifa.rsp1_q), 32'h A5);

      // Both ports hold valid: read addr 1 on port 0, write 0x3C to addr 1 on port 1.
      gnt_log.delete(); rd0_log.delete();
      pv[0] = 1'b1; pwe[0] = 1'b0; pa[0] = 4'd1; pd[0] = 8'h00; mode[0] = 1; took[0] = 1'b0;
      pv[1] = 1'b1; pwe[1] = 1'b1; pa[1] = 4'd1; pd[1] = 8'h3C; mode[1] = 1; took[1] = 1'b0;
      repeat (12) tick();
      pv[0] = 1'b0; pv[1] = 1'b0; mode[0] = 0; mode[1] = 0;
      repeat (4) tick();
      chk("contention_grants", gnt_log.size() >= 4 ? 1 : 0, 1);
      if (gnt_log.size() >= 4)
         chk("grant_order", 32'({gnt_log[0][0], gnt_log[1][0], gnt_log[2][0], gnt_log[3][0]}), 32'b0101);
      chk("contention_reads", rd0_log.size() >= 2 ? 1 : 0, 1);
      if (rd0_log.size() >= 2) begin
         chk("rd_before_wr", 32'(rd0_log[0]), 32'h00);
         chk("rd_after_wr", 32'(rd0_log[1]), 32'h3C);
      end

      mode[0] = 2; mode[1] = 2;
      repeat (400) tick();
      pv[0] = 1'b0; pv[1] = 1'b0; mode[0] = 0; mode[1] = 0;
      repeat (4) tick();

      // Reset lands in the WAIT cycle of a read: response dropped, sweep restarts.
      pv[0] = 1'b1; pwe[0] = 1'b0; pa[0] = 4'd5; took[0] = 1'b0;
      begin
         int n = 0;
         while (!took[0] && n < 50) begin tick(); n++; end
         if (n >= 50) chk("midrd_timeout", 0, 1);
      end
      tick();
      rst_a = 1'b1;
      #1;
      check_zero("midrd_async");
      @(posedge clock); #1;
      check_zero("midrd_hold");
      @(negedge clock);
      rst_a = 1'b0;
      model_reset();
      drive_a();
      repeat (22) tick();
      issue(1, 1'b0, 4'd5, 8'h00);

      // Instance without the sweep.
      @(negedge clock);
      rst_b = 1'b0;
      @(negedge clock);
      chk("b_init_done", 32'(ifb.init_done), 1);
      for (int i = 0; i < 10; i++) begin
         chk("b_no_we", 32'(ifb.ram_we), 0);
         @(negedge clock);
      end
      ifb.req1_valid = 1'b1; ifb.req1_we = 1'b1; ifb.req1_addr = 4'd2; ifb.req1_d = 8'h5A;
      #1;
      chk("b_ready1", 32'(ifb.req1_ready), 1);
      @(negedge clock);
      ifb.req1_valid = 1'b0;
      chk("b_wr_bus", 32'({ifb.ram_we, ifb.ram_addr, ifb.ram_d}), 32'({1'b1, 4'd2, 8'h5A}));
      @(negedge clock);
      chk("b_wr_rsp", 32'({ifb.rsp1_valid, ifb.ram_we}), 32'b10);
      ifb.req0_valid = 1'b1; ifb.req0_we = 1'b0; ifb.req0_addr = 4'd2;
      #1;
      chk("b_ready0", 32'(ifb.req0_ready), 1);
      @(negedge clock);
      ifb.req0_valid = 1'b0;
      chk("b_rd_we", 32'(ifb.ram_we), 0);
      @(negedge clock);
      chk("b_rd_early", 32'(ifb.rsp0_valid), 0);
      @(negedge clock);
      chk("b_rd_rsp", 32'({ifb.rsp0_valid, ifb.rsp0_q}), 32'({1'b1, 8'h5A}));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
